// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the register-file clear-sequencer state type.
package mips_pkg;

    localparam logic [5:0] R_FORM = 6'h00;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ANDI   = 6'h0C;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] XORI   = 6'h0E;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2B;

    localparam logic [5:0] JR     = 6'h08;

    typedef enum logic {CLEAR, READY} clr_state_t;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic zero_ext_op(input logic [5:0] op);
        return (op == ANDI) || (op == ORI) || (op == XORI);
    endfunction

endpackage

// File: rtl/id_regfile_array.sv
// NREG x DATA_W storage: one synchronous write port, three asynchronous read ports, entry 0 hard-wired to zero.
module id_regfile_array #(
    parameter int DATA_W = 32,
    parameter int AREG_W = 5
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [AREG_W-1:0] wadr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AREG_W-1:0] radr1,
    input  logic [AREG_W-1:0] radr2,
    input  logic [AREG_W-1:0] radr3,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] rdata3
);
    localparam int NREG = 1 << AREG_W;

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge CLK) begin
        if (we && (wadr != '0))
            mem[wadr] <= wdata;
    end

    assign rdata1 = (radr1 == '0) ? '0 : mem[radr1];
    assign rdata2 = (radr2 == '0) ? '0 : mem[radr2];
    assign rdata3 = (radr3 == '0) ? '0 : mem[radr3];

endmodule

// File: rtl/id_regfile.sv
// Instruction-decode register file: field decode, immediate extension, bypassed reads
// and a post-reset sequencer that zeroes every entry before the pipeline may use it.
module id_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int AREG_W     = 5,
    parameter int BYPASS     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [31:0]       Ins,
    input  logic              WE,
    input  logic [AREG_W-1:0] WADR,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [AREG_W-1:0] DBG_ADR,
    output logic [DATA_W-1:0] Rdata1,
    output logic [DATA_W-1:0] Rdata2,
    output logic [DATA_W-1:0] Ed32,
    output logic [DATA_W-1:0] DBG_DATA,
    output logic              BUSY,
    output logic              DROP
);
    localparam int NREG = 1 << AREG_W;

    logic [5:0]        op;
    logic [AREG_W-1:0] rs;
    logic [AREG_W-1:0] rt;
    logic [15:0]       imm;

    assign op  = Ins[31:26];
    assign rs  = Ins[21 +: AREG_W];
    assign rt  = Ins[16 +: AREG_W];
    assign imm = Ins[15:0];

    assign Ed32 = zero_ext_op(op) ? DATA_W'(imm) : DATA_W'($signed(imm));

    logic              clr_busy;
    logic [AREG_W-1:0] clr_adr;

    generate
        if (INIT_CLEAR != 0) begin : g_clear
            clr_state_t        state;
            logic [AREG_W-1:0] cnt;
            logic              busy_r;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    state  <= CLEAR;
                    cnt    <= AREG_W'(1);
                    busy_r <= 1'b1;
                end else begin
                    case (state)
                        CLEAR: begin
                            if (cnt == AREG_W'(NREG - 1)) begin
                                state  <= READY;
                                busy_r <= 1'b0;
                            end else begin
                                cnt <= cnt + AREG_W'(1);
                            end
                        end
                        default: begin
                            state  <= READY;
                            busy_r <= 1'b0;
                        end
                    endcase
                end
            end

            assign clr_busy = busy_r;
            assign clr_adr  = cnt;
        end else begin : g_noclear
            assign clr_busy = 1'b0;
            assign clr_adr  = '0;
        end
    endgenerate

    assign BUSY = clr_busy;

    logic user_wr;
    assign user_wr = WE && !clr_busy && (WADR != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            DROP <= 1'b0;
        else
            DROP <= WE && clr_busy && (WADR != '0);
    end

    // The clear sequencer owns the write port while busy; user writes are discarded.
    logic              arr_we;
    logic [AREG_W-1:0] arr_wadr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rd1;
    logic [DATA_W-1:0] arr_rd2;
    logic [DATA_W-1:0] arr_rd3;

    assign arr_we    = clr_busy || user_wr;
    assign arr_wadr  = clr_busy ? clr_adr : WADR;
    assign arr_wdata = clr_busy ? '0 : WDATA;

    id_regfile_array #(
        .DATA_W (DATA_W),
        .AREG_W (AREG_W)
    ) u_array (
        .CLK    (CLK),
        .we     (arr_we),
        .wadr   (arr_wadr),
        .wdata  (arr_wdata),
        .radr1  (rs),
        .radr2  (rt),
        .radr3  (DBG_ADR),
        .rdata1 (arr_rd1),
        .rdata2 (arr_rd2),
        .rdata3 (arr_rd3)
    );

    logic byp1;
    logic byp2;
    assign byp1 = (BYPASS != 0) && user_wr && (WADR == rs);
    assign byp2 = (BYPASS != 0) && user_wr && (WADR == rt);

    assign Rdata1   = clr_busy ? '0 : (byp1 ? WDATA : arr_rd1);
    assign Rdata2   = clr_busy ? '0 : (byp2 ? WDATA : arr_rd2);
    assign DBG_DATA = clr_busy ? '0 : arr_rd3;

endmodule

// File: tb/tb_id_regfile.sv
// Bench for id_regfile: bypassed and non-bypassed instances share stimulus and a behavioural model.
module tb_id_regfile;
    import mips_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] ins;
    logic        we;
    logic [4:0]  wadr;
    logic [31:0] wdata;
    logic [4:0]  dbg_adr;

    logic [31:0] rd1_b, rd2_b, ed_b, dbg_b;
    logic        busy_b, drop_b;
    logic [31:0] rd1_n, rd2_n, ed_n, dbg_n;
    logic        busy_n, drop_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    id_regfile #(.DATA_W(32), .AREG_W(5), .BYPASS(1), .INIT_CLEAR(1)) u_byp (
        .CLK(CLK), .RST_N(RST_N), .Ins(ins), .WE(we), .WADR(wadr), .WDATA(wdata),
        .DBG_ADR(dbg_adr), .Rdata1(rd1_b), .Rdata2(rd2_b), .Ed32(ed_b),
        .DBG_DATA(dbg_b), .BUSY(busy_b), .DROP(drop_b)
    );

    id_regfile #(.DATA_W(32), .AREG_W(5), .BYPASS(0), .INIT_CLEAR(1)) u_nob (
        .CLK(CLK), .RST_N(RST_N), .Ins(ins), .WE(we), .WADR(wadr), .WDATA(wdata),
        .DBG_ADR(dbg_adr), .Rdata1(rd1_n), .Rdata2(rd2_n), .Ed32(ed_n),
        .DBG_DATA(dbg_n), .BUSY(busy_n), .DROP(drop_n)
    );

    // Reference model: architectural register contents after every committed write.
    logic [31:0] mem [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ext_model(input logic [31:0] i);
        logic [5:0]  o;
        logic [15:0] m;
        o = i[31:26];
        m = i[15:0];
        if (o == ANDI || o == ORI || o == XORI)
            return {16'h0000, m};
        return {{16{m[15]}}, m};
    endfunction

    function automatic logic [31:0] mk_ins(input logic [5:0] o, input logic [4:0] s,
                                           input logic [4:0] t, input logic [15:0] m);
        return {o, s, t, m};
    endfunction

    // Counts cycles BUSY stays high; optionally injects a user write on the first cycle.
    task automatic count_busy(input bit inject, output int n);
        n = 0;
        while (busy_b && n < 40) begin
            if (inject && n == 0) begin
                ins = mk_ins(ADDI, 5'd17, 5'd17, 16'h0000);
                we = 1'b1; wadr = 5'd17; wdata = 32'h0000_1234;
                #1;
                chk("busy_rd1_zero", rd1_b, 32'h0);
            end
            @(posedge CLK); #1;
            n++;
            if (inject && n == 1) begin
                chk("drop_pulse", {31'b0, drop_b}, 32'h1);
                we = 1'b0;
            end
            if (inject && n == 2)
                chk("drop_one_cycle", {31'b0, drop_b}, 32'h0);
        end
    endtask

    task automatic check_all_zero(input string nm);
        for (int a = 0; a < 32; a++) begin
            dbg_adr = a[4:0];
            #0.1;
            chk(nm, dbg_b, 32'h0);
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] ed;
    } imm_vec_t;

    imm_vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [4:0]  rs_i, rt_i;
        logic [31:0] e1b, e2b, e1n, e2n;

        tbl[0] = '{mk_ins(ORI,    5'd0, 5'd0, 16'h8001), 32'h0000_8001};
        tbl[1] = '{mk_ins(ADDI,   5'd0, 5'd0, 16'h8001), 32'hFFFF_8001};
        tbl[2] = '{mk_ins(SW,     5'd0, 5'd0, 16'h0004), 32'h0000_0004};
        tbl[3] = '{mk_ins(ANDI,   5'd1, 5'd2, 16'hFFFF), 32'h0000_FFFF};
        tbl[4] = '{mk_ins(XORI,   5'd3, 5'd4, 16'h8000), 32'h0000_8000};
        tbl[5] = '{mk_ins(LW,     5'd5, 5'd6, 16'h8000), 32'hFFFF_8000};
        tbl[6] = '{mk_ins(BEQ,    5'd7, 5'd8, 16'hFFFF), 32'hFFFF_FFFF};
        tbl[7] = '{mk_ins(R_FORM, 5'd9, 5'd9, 16'h7FFF), 32'h0000_7FFF};

        for (int a = 0; a < 32; a++) mem[a] = 32'h0;

        RST_N = 1'b0;
        ins = mk_ins(ADDI, 5'd3, 5'd4, 16'h8001);
        we = 1'b0; wadr = 5'd0; wdata = 32'h0; dbg_adr = 5'd3;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy_b", {31'b0, busy_b}, 32'h1);
        chk("rst_busy_n", {31'b0, busy_n}, 32'h1);
        chk("rst_drop",   {31'b0, drop_b}, 32'h0);
        chk("rst_rd1",    rd1_b, 32'h0);
        chk("rst_rd2",    rd2_n, 32'h0);
        chk("rst_dbg",    dbg_b, 32'h0);
        chk("rst_ed32",   ed_b,  32'hFFFF_8001);

        RST_N = 1'b1;
        count_busy(1'b0, n);
        chk("busy_len_first", n, 32'd31);
        chk("busy_n_low", {31'b0, busy_n}, 32'h0);
        check_all_zero("clear_dbg_zero");

        // Same-cycle write to the register being read.
        ins = mk_ins(R_FORM, 5'd10, 5'd0, 16'h0000);
        we = 1'b1; wadr = 5'd10; wdata = 32'h5;
        #1;
        chk("bypass_on_same",  rd1_b, 32'h5);
        chk("bypass_off_same", rd1_n, 32'h0);
        @(posedge CLK); #1;
        mem[10] = 32'h5;
        we = 1'b0;
        #1;
        chk("bypass_on_next",  rd1_b, 32'h5);
        chk("bypass_off_next", rd1_n, 32'h5);

        // Writes to register 0 vanish.
        ins = mk_ins(R_FORM, 5'd0, 5'd0, 16'h0000);
        we = 1'b1; wadr = 5'd0; wdata = 32'hFFFF_FFFF; dbg_adr = 5'd0;
        #1;
        chk("r0_rd1_same", rd1_b, 32'h0);
        chk("r0_rd2_same", rd2_b, 32'h0);
        @(posedge CLK); #1;
        we = 1'b0;
        #1;
        chk("r0_drop", {31'b0, drop_b}, 32'h0);
        chk("r0_rd1",  rd1_b, 32'h0);
        chk("r0_rd2n", rd2_n, 32'h0);
        chk("r0_dbg",  dbg_b, 32'h0);

        for (int k = 0; k < 8; k++) begin
            ins = tbl[k].ins;
            #1;
            chk("imm_tbl_b", ed_b, tbl[k].ed);
            chk("imm_tbl_n", ed_n, tbl[k].ed);
        end

        @(posedge CLK); #1;
        for (int k = 0; k < 300; k++) begin
            ins     = $urandom;
            rs_i    = ins[25:21];
            rt_i    = ins[20:16];
            we      = $urandom_range(0, 1) == 1;
            wadr    = ($urandom_range(0, 2) == 0) ? rs_i : 5'($urandom_range(0, 31));
            wdata   = $urandom;
            dbg_adr = 5'($urandom_range(0, 31));
            #1;
            e1n = mem[rs_i];
            e2n = mem[rt_i];
            e1b = (we && wadr != 0 && wadr == rs_i) ? wdata : e1n;
            e2b = (we && wadr != 0 && wadr == rt_i) ? wdata : e2n;
            chk("rnd_rd1_b", rd1_b, e1b);
            chk("rnd_rd2_b", rd2_b, e2b);
            chk("rnd_rd1_n", rd1_n, e1n);
            chk("rnd_rd2_n", rd2_n, e2n);
            chk("rnd_dbg",   dbg_b, mem[dbg_adr]);
            chk("rnd_ed32",  ed_b,  ext_model(ins));
            @(posedge CLK);
            if (we && wadr != 0) mem[wadr] = wdata;
            #1;
            chk("rnd_drop", {31'b0, drop_b}, 32'h0);
        end
        we = 1'b0;

        ins = 32'h0;
        we = 1'b1; wadr = 5'd5; wdata = 32'h0000_ABCD;
        @(posedge CLK); #1;
        wadr = 5'd17; wdata = 32'h0000_0077;
        @(posedge CLK); #1;
        we = 1'b0; dbg_adr = 5'd17;
        #0.5;
        chk("pre_rst_r17", dbg_b, 32'h0000_0077);

        // Reset, then reset again once the sequencer has reached CNT=12.
        RST_N = 1'b0; #2; RST_N = 1'b1;
        repeat (11) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("midclr_busy", {31'b0, busy_b}, 32'h1);
        chk("midclr_drop", {31'b0, drop_b}, 32'h0);
        #1;
        RST_N = 1'b1;
        count_busy(1'b1, n);
        chk("busy_len_restart", n, 32'd31);
        for (int a = 0; a < 32; a++) mem[a] = 32'h0;
        check_all_zero("restart_dbg_zero");
        ins = mk_ins(R_FORM, 5'd5, 5'd17, 16'h0);
        #1;
        chk("restart_r5",  rd1_b, mem[5]);
        chk("restart_r17", rd2_n, mem[17]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
